// File: rtl/interrupt_controller_prio_if.sv
// Register-bus, request-line and CPU handshake bundle for interrupt_controller_prio.
`timescale 1ns/1ps
interface interrupt_controller_prio_if #(
  parameter int unsigned NUM_SOURCES = 5
);
  logic                   iMcuWe;
  logic [3:0]             iMcuRegSelect;
  logic [7:0]             iMcuWriteData;
  logic                   iIme;
  logic [NUM_SOURCES-1:0] iInterruptRequest;
  logic                   iIrqAck;
  logic [7:0]             oInterruptEnableRegister;
  logic [7:0]             oInterruptFlag;
  logic                   oIrq;
  logic [2:0]             oIrqIndex;
  logic [15:0]            oIrqVector;
  logic                   oWake;

  modport master (
    output iMcuWe, iMcuRegSelect, iMcuWriteData, iIme, iInterruptRequest, iIrqAck,
    input  oInterruptEnableRegister, oInterruptFlag, oIrq, oIrqIndex, oIrqVector, oWake
  );

  modport slave (
    input  iMcuWe, iMcuRegSelect, iMcuWriteData, iIme, iInterruptRequest, iIrqAck,
    output oInterruptEnableRegister, oInterruptFlag, oIrq, oIrqIndex, oIrqVector, oWake
  );
endinterface

// File: rtl/interrupt_controller_prio.sv
// Fixed-priority interrupt controller with IE/IF registers and a req/ack CPU handshake.
// Optional macro IRQ_EDGE_DETECT_EN: request lines are rising-edge detected instead of level.
`timescale 1ns/1ps
module interrupt_controller_prio #(
  parameter int unsigned NUM_SOURCES   = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int unsigned VECTOR_STRIDE = 8
) (
  input logic                        iClock,
  input logic                        iReset_n,
  interrupt_controller_prio_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             ie_q;
  logic [NUM_SOURCES-1:0] if_q, if_d;
  logic [NUM_SOURCES-1:0] src_event, pending, ack_clr;
  logic [2:0]             index_q, index_d, winner;
  logic [15:0]            vector_q, vector_d;
  logic                   any_pending;
  logic                   we_ie, we_if;
  logic [7:0]             flag_view;

  assign we_ie   = bus.iMcuWe && (bus.iMcuRegSelect == 4'h0);
  assign we_if   = bus.iMcuWe && (bus.iMcuRegSelect == 4'hF);
  assign pending = if_q & ie_q[NUM_SOURCES-1:0];

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_SOURCES-1:0] req_prev;

  // Cleared on reset so a line already high at reset release counts as one edge.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) req_prev <= '0;
    else           req_prev <= bus.iInterruptRequest;
  end

  assign src_event = bus.iInterruptRequest & ~req_prev;
`else
  assign src_event = bus.iInterruptRequest;
`endif

  always_comb begin
    winner      = '0;
    any_pending = 1'b0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (pending[i] && !any_pending) begin
        winner      = 3'(i);
        any_pending = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    vector_d = vector_q;
    ack_clr  = '0;
    case (state_q)
      IDLE: begin
        if (bus.iIme && any_pending) begin
          index_d  = winner;
          vector_d = VECTOR_BASE + 16'(winner) * 16'(VECTOR_STRIDE);
          state_d  = REQ;
        end
      end
      REQ: begin
        if (bus.iIrqAck) begin
          ack_clr[index_q] = 1'b1;
          state_d          = HOLD;
        end else if (!bus.iIme || !pending[index_q]) begin
          state_d = IDLE;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A source event outranks both software writes and ack clears, so no request is lost.
  always_comb begin
    if_d = if_q;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (src_event[i])    if_d[i] = 1'b1;
      else if (we_if)      if_d[i] = bus.iMcuWriteData[i];
      else if (ack_clr[i]) if_d[i] = 1'b0;
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q  <= IDLE;
      ie_q     <= '0;
      if_q     <= '0;
      index_q  <= '0;
      vector_q <= VECTOR_BASE;
    end else begin
      state_q  <= state_d;
      if_q     <= if_d;
      index_q  <= index_d;
      vector_q <= vector_d;
      if (we_ie) ie_q <= bus.iMcuWriteData;
    end
  end

  always_comb begin
    flag_view                  = '1;
    flag_view[NUM_SOURCES-1:0] = if_q;
  end

  assign bus.oInterruptEnableRegister = ie_q;
  assign bus.oInterruptFlag           = flag_view;
  assign bus.oIrq                     = (state_q == REQ);
  assign bus.oIrqIndex                = index_q;
  assign bus.oIrqVector               = vector_q;
  assign bus.oWake                    = |pending;
endmodule

// File: tb/tb_interrupt_controller_prio.sv
// Self-checking bench for interrupt_controller_prio: register vector table plus handshake sequences.
`timescale 1ns/1ps
module tb_interrupt_controller_prio;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  interrupt_controller_prio_if #(.NUM_SOURCES(5)) bus ();

  interrupt_controller_prio #(
    .NUM_SOURCES  (5),
    .VECTOR_BASE  (16'h0040),
    .VECTOR_STRIDE(8)
  ) dut (
    .iClock  (clk),
    .iReset_n(rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic       we;
    logic [3:0] sel;
    logic [7:0] data;
    logic [4:0] req;
    logic [7:0] ie;
    logic [7:0] flag;
    logic       wake;
  } vec_t;

  typedef struct {
    logic [7:0] ie;
    logic [7:0] flag;
    logic       wake;
    logic       irq;
  } exp_t;

  vec_t tbl[10];
  exp_t sbq[$];
  exp_t got;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [7:0] data);
    bus.iMcuWe        = 1'b1;
    bus.iMcuRegSelect = sel;
    bus.iMcuWriteData = data;
    step();
    bus.iMcuWe        = 1'b0;
  endtask

  task automatic chk_req(input string name, input logic [2:0] idx, input logic [15:0] vec);
    chk({name, "_irq"}, 16'(bus.oIrq), 16'd1);
    chk({name, "_idx"}, 16'(bus.oIrqIndex), 16'(idx));
    chk({name, "_vec"}, bus.oIrqVector, vec);
  endtask

  initial begin
    logic lvl_bit4;
`ifdef IRQ_EDGE_DETECT_EN
    lvl_bit4 = 1'b0;
`else
    lvl_bit4 = 1'b1;
`endif
    //            we    sel    data   req       ie     flag   wake
    tbl[0] = '{1'b1, 4'h0, 8'h1F, 5'b00000, 8'h1F, 8'hE0, 1'b0};
    tbl[1] = '{1'b0, 4'h0, 8'h00, 5'b00100, 8'h1F, 8'hE4, 1'b1};
    tbl[2] = '{1'b1, 4'hF, 8'h03, 5'b00000, 8'h1F, 8'hE3, 1'b1};
    tbl[3] = '{1'b1, 4'h3, 8'hFF, 5'b00000, 8'h1F, 8'hE3, 1'b1};
    tbl[4] = '{1'b1, 4'hF, 8'h00, 5'b00010, 8'h1F, 8'hE2, 1'b1};
    tbl[5] = '{1'b1, 4'h0, 8'h00, 5'b00000, 8'h00, 8'hE2, 1'b0};
    tbl[6] = '{1'b1, 4'hF, 8'hFF, 5'b00000, 8'h00, 8'hFF, 1'b0};
    tbl[7] = '{1'b1, 4'h0, 8'h10, 5'b00000, 8'h10, 8'hFF, 1'b1};
    tbl[8] = '{1'b1, 4'hF, 8'h00, 5'b00000, 8'h10, 8'hE0, 1'b0};
    tbl[9] = '{1'b1, 4'h0, 8'h00, 5'b00000, 8'h00, 8'hE0, 1'b0};

    bus.iMcuWe = 1'b0; bus.iMcuRegSelect = 4'h0; bus.iMcuWriteData = 8'h00;
    bus.iIme = 1'b0; bus.iInterruptRequest = '0; bus.iIrqAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ie", 16'(bus.oInterruptEnableRegister), 16'h00);
    chk("rst_if", 16'(bus.oInterruptFlag), 16'hE0);
    chk("rst_irq", 16'(bus.oIrq), 16'd0);
    chk("rst_idx", 16'(bus.oIrqIndex), 16'd0);
    chk("rst_vec", bus.oIrqVector, 16'h0040);
    chk("rst_wake", 16'(bus.oWake), 16'd0);
    rst_n = 1'b1;
    step();

    // Register behaviour with iIme low: expected values queued at drive time.
    for (int i = 0; i < 10; i++) begin
      bus.iMcuWe = tbl[i].we; bus.iMcuRegSelect = tbl[i].sel;
      bus.iMcuWriteData = tbl[i].data; bus.iInterruptRequest = tbl[i].req;
      sbq.push_back('{tbl[i].ie, tbl[i].flag, tbl[i].wake, 1'b0});
      step();
      got = sbq.pop_front();
      chk($sformatf("vec%0d_ie", i), 16'(bus.oInterruptEnableRegister), 16'(got.ie));
      chk($sformatf("vec%0d_if", i), 16'(bus.oInterruptFlag), 16'(got.flag));
      chk($sformatf("vec%0d_wake", i), 16'(bus.oWake), 16'(got.wake));
      chk($sformatf("vec%0d_irq", i), 16'(bus.oIrq), 16'(got.irq));
    end
    bus.iMcuWe = 1'b0; bus.iInterruptRequest = '0;

    // Priority: sources 2 and 0 together, 0 served first.
    wr(4'h0, 8'h1F);
    bus.iIme = 1'b1; bus.iInterruptRequest = 5'b00101;
    step();
    chk("prio_if", 16'(bus.oInterruptFlag), 16'hE5);
    chk("prio_irq0", 16'(bus.oIrq), 16'd0);
    bus.iInterruptRequest = '0;
    step();
    chk_req("prio_first", 3'd0, 16'h0040);
    bus.iIrqAck = 1'b1; step(); bus.iIrqAck = 1'b0;
    chk("prio_ack_if", 16'(bus.oInterruptFlag), 16'hE4);
    chk("prio_hold_irq", 16'(bus.oIrq), 16'd0);
    step();
    chk("prio_idle_irq", 16'(bus.oIrq), 16'd0);
    step();
    chk_req("prio_second", 3'd2, 16'h0050);
    bus.iIrqAck = 1'b1; step(); bus.iIrqAck = 1'b0;
    chk("prio_ack2_if", 16'(bus.oInterruptFlag), 16'hE0);
    step(); step();
    chk("prio_quiet", 16'(bus.oIrq), 16'd0);

    // Gating by iIme.
    bus.iIme = 1'b0;
    wr(4'h0, 8'h04);
    bus.iInterruptRequest = 5'b00100; step(); bus.iInterruptRequest = '0;
    chk("gate_if", 16'(bus.oInterruptFlag), 16'hE4);
    chk("gate_wake", 16'(bus.oWake), 16'd1);
    chk("gate_irq_a", 16'(bus.oIrq), 16'd0);
    step();
    chk("gate_irq_b", 16'(bus.oIrq), 16'd0);
    bus.iIme = 1'b1; step();
    chk_req("gate_req", 3'd2, 16'h0050);
    bus.iIrqAck = 1'b1; step(); bus.iIrqAck = 1'b0;
    step();

    // Withdraw on software IF clear.
    wr(4'h0, 8'h1F);
    bus.iInterruptRequest = 5'b00010; step(); bus.iInterruptRequest = '0;
    step();
    chk_req("wd_req", 3'd1, 16'h0048);
    wr(4'hF, 8'h00);
    chk("wd_if", 16'(bus.oInterruptFlag), 16'hE0);
    step();
    chk("wd_irq", 16'(bus.oIrq), 16'd0);
    chk("wd_ie", 16'(bus.oInterruptEnableRegister), 16'h1F);
    step();
    chk("wd_idle", 16'(bus.oIrq), 16'd0);

    // Source event coincident with ack of the same bit.
    bus.iInterruptRequest = 5'b01000; step(); bus.iInterruptRequest = '0;
    step();
    chk_req("col_req", 3'd3, 16'h0058);
    bus.iIrqAck = 1'b1; bus.iInterruptRequest = 5'b01000;
    step();
    bus.iIrqAck = 1'b0; bus.iInterruptRequest = '0;
    chk("col_if", 16'(bus.oInterruptFlag), 16'hE8);
    chk("col_hold", 16'(bus.oIrq), 16'd0);
    step(); step();
    chk_req("col_again", 3'd3, 16'h0058);
    bus.iIrqAck = 1'b1; step(); bus.iIrqAck = 1'b0;
    step();

    // Asynchronous reset in the middle of REQ.
    bus.iInterruptRequest = 5'b00001; step(); bus.iInterruptRequest = '0;
    step();
    chk_req("ar_req", 3'd0, 16'h0040);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_irq", 16'(bus.oIrq), 16'd0);
    chk("ar_if", 16'(bus.oInterruptFlag), 16'hE0);
    chk("ar_ie", 16'(bus.oInterruptEnableRegister), 16'h00);
    chk("ar_wake", 16'(bus.oWake), 16'd0);
    rst_n = 1'b1;
    step();

    // Line held high across an ack.
    wr(4'h0, 8'h10);
    bus.iInterruptRequest = 5'b10000;
    step();
    chk("hold_set", 16'(bus.oInterruptFlag[4]), 16'd1);
    step();
    chk_req("hold_req", 3'd4, 16'h0060);
    bus.iIrqAck = 1'b1; step(); bus.iIrqAck = 1'b0;
    chk("hold_after_ack", 16'(bus.oInterruptFlag[4]), 16'(lvl_bit4));
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("hold_bit4_%0d", k), 16'(bus.oInterruptFlag[4]), 16'(lvl_bit4));
    end
    bus.iInterruptRequest = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
